pair_pop_queue: RTL and testbench
=================================

# pair_pop_queue

Parametrised shift-register token queue with single-entry push and one-or-two-entry pop per cycle. The block buffers W-bit tokens for the calculator datapath and presents the head entry, or the head pair, as a concatenated registered word. It adds push back-pressure, occupancy count, flush, underflow reporting and per-half valid flags. Unused output halves are filled with a pad token.

## Interface
- W, 8, token width in bits
- DEPTH, 5, number of entries (>= 2)
- PAD, 10, W-bit filler token for output halves that carry no data
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of queue contents
- push_valid  in  1  push request
- push_data  in  W  token to append at tail
- push_ready  out  1  combinational, = (count != DEPTH)
- pop_en  in  1  pop request
- pop_two  in  1  0: pop one entry, 1: pop two entries (ignored when pop_en=0)
- top_conc  out  2W  registered, {first popped, second popped or PAD}
- top_vld  out  2  registered, bit1 = upper half valid, bit0 = lower half valid
- count  out  CW  registered occupancy, 0..DEPTH
- underflow  out  1  registered one-cycle pulse, pop requested more than count

## Operation
- Storage: arr[0..DEPTH-1], arr[0] = head. Entries at index >= count are always 0.
- Request sizes: p_req = pop_en ? (pop_two ? 2 : 1) : 0. p_eff = min(p_req, count). push_acc = push_valid & push_ready.
- Pop output, when pop_en=1:
  - top_conc[2W-1:W] <= (count>=1) ? arr[0] : PAD.
  - top_conc[W-1:0] <= pop_two ? ((count>=2) ? arr[1] : PAD) : PAD.
  - top_vld <= {count>=1, pop_two & (count>=2)}.
- When pop_en=0: top_conc holds its value and top_vld <= 2'b00.
- Shift: arr[i] <= arr[i+p_eff] for i+p_eff < DEPTH. All vacated slots <= 0.
- Push: the accepted token is written at index count - p_eff, the post-shift tail.
- count <= count - p_eff + push_acc.
- underflow <= pop_en & (p_req > count). Valid entries are still popped. No partial error recovery is needed.
- Priority: rst > flush > pop/push.
- flush: arr all 0, count <= 0, top_vld <= 0, underflow <= 0. top_conc holds. A push in the same cycle is dropped.
- Full with simultaneous pop: push_ready = 0 because it does not look ahead at the pop, so the push is not accepted. The upstream must retry.
- Empty with simultaneous push and pop: p_eff = 0, the token is stored at arr[0], underflow pulses, and the output is PAD halves with top_vld = 0.

## Timing
- Reset values: arr all 0, top_conc = 0, top_vld = 0, count = 0, underflow = 0. push_ready = 1 during and after reset.
- Push-to-visibility latency is 1 cycle. A token pushed at edge N can be popped by a request sampled at edge N+1.
- Pop result appears on top_conc/top_vld one cycle after pop_en is sampled.
- push_ready is combinational from the registered count only. It has no combinational path from any input.
- rst asserted mid-operation clears everything at the next edge and discards that cycle's requests.
- No combinational path from pop_en/push_valid to any output.

## Test plan
- Reset then push 8'h11, 8'h22, 8'h33. Then pop_en=1, pop_two=1 -> top_conc=16'h1122, top_vld=2'b11, count=1, and arr[0]=8'h33.
- Push 8'h44 only. Then pop_two=0 -> top_conc=16'h440A, top_vld=2'b10, count=0.
- Fill DEPTH=5 with 1..5 -> push_ready=0. Pop one plus push 8'h66 in the same cycle -> push dropped, count=4. Next cycle push_ready=1.
- count=1 holding 8'hAA, pop_two=1 -> top_conc=16'hAA0A, top_vld=2'b10, underflow pulses one cycle, count=0.
- count=3, simultaneous pop_two=1 and push 8'h77 -> count=2, arr[1]=8'h77. The next pop_two returns {old arr[2], 8'h77}.
- count=4, assert flush with push_valid=1 -> count=0, underflow=0, top_conc unchanged. Assert rst after pushes -> all outputs 0.

Source files
------------

// File: rtl/pair_pop_queue_if.sv
// rtl/pair_pop_queue_if.sv - push/pop handshake bundle for the pair-pop token queue
interface pair_pop_queue_if #(
  parameter int W     = 8,
  parameter int DEPTH = 5,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic          flush;
  logic          push_valid;
  logic [W-1:0]  push_data;
  logic          push_ready;
  logic          pop_en;
  logic          pop_two;
  logic [2*W-1:0] top_conc;
  logic [1:0]    top_vld;
  logic [CW-1:0] count;
  logic          underflow;

  modport master (
    output flush, push_valid, push_data, pop_en, pop_two,
    input  push_ready, top_conc, top_vld, count, underflow
  );

  modport slave (
    input  flush, push_valid, push_data, pop_en, pop_two,
    output push_ready, top_conc, top_vld, count, underflow
  );
endinterface

// File: rtl/pair_pop_queue.sv
// rtl/pair_pop_queue.sv - shift-register token queue, single push, one-or-two pop per cycle
module pair_pop_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 5,
  parameter int PAD   = 10,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  pair_pop_queue_if.slave q
);
  localparam logic [W-1:0]  PAD_TOK = PAD[W-1:0];
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  logic [W-1:0]  arr [DEPTH];
  logic [W-1:0]  ext [DEPTH+2];
  logic [W-1:0]  nxt [DEPTH];
  logic [CW-1:0] cnt;
  logic [1:0]    p_req;
  logic [1:0]    p_eff;
  logic          push_acc;

  assign q.push_ready = (cnt != FULL);
  assign q.count      = cnt;

  // Pop sizing: clip the request to what the queue actually holds.
  always_comb begin
    p_req = 2'd0;
    if (q.pop_en) p_req = q.pop_two ? 2'd2 : 2'd1;
    p_eff = (CW'(p_req) > cnt) ? cnt[1:0] : p_req;
    push_acc = q.push_valid & (cnt != FULL);
  end

  // Next storage image: shift out popped entries, zero-fill, then drop the push at the new tail.
  always_comb begin
    for (int i = 0; i < DEPTH + 2; i++) ext[i] = '0;
    for (int i = 0; i < DEPTH; i++) ext[i] = arr[i];
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = ext[i + int'(p_eff)];
      if (push_acc && (i == int'(cnt) - int'(p_eff))) nxt[i] = q.push_data;
    end
  end

  // State update with priority reset, then flush, then normal pop/push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
      cnt         <= '0;
      q.top_conc  <= '0;
      q.top_vld   <= 2'b00;
      q.underflow <= 1'b0;
    end else if (q.flush) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
      cnt         <= '0;
      q.top_vld   <= 2'b00;
      q.underflow <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= nxt[i];
      cnt         <= cnt - CW'(p_eff) + CW'(push_acc);
      q.underflow <= q.pop_en & (CW'(p_req) > cnt);
      if (q.pop_en) begin
        q.top_conc <= {(cnt >= CW'(1)) ? arr[0] : PAD_TOK,
                       (q.pop_two && cnt >= CW'(2)) ? arr[1] : PAD_TOK};
        q.top_vld  <= {cnt >= CW'(1), q.pop_two & (cnt >= CW'(2))};
      end else begin
        q.top_vld  <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_pair_pop_queue.sv
// tb/tb_pair_pop_queue.sv - self-checking bench for pair_pop_queue
module tb_pair_pop_queue;
  localparam int W = 8;
  localparam int DEPTH = 5;
  localparam logic [7:0] PADV = 8'h0A;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  bit   chk_en;

  pair_pop_queue_if #(.W(W), .DEPTH(DEPTH)) bus ();

  pair_pop_queue #(.W(W), .DEPTH(DEPTH), .PAD(10)) dut (
    .clk(clk),
    .rst(rst),
    .q  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a plain token queue plus expected output registers.
  logic [7:0]  mq[$];
  logic [15:0] e_conc;
  logic [1:0]  e_vld;
  bit          e_uf;

  always @(posedge clk) begin
    int preq;
    int n;
    int pe;
    bit acc;
    if (rst) begin
      mq.delete();
      e_conc = 16'h0;
      e_vld  = 2'b00;
      e_uf   = 1'b0;
    end else if (bus.flush) begin
      mq.delete();
      e_vld = 2'b00;
      e_uf  = 1'b0;
    end else begin
      preq = bus.pop_en ? (bus.pop_two ? 2 : 1) : 0;
      n    = mq.size();
      acc  = bus.push_valid && (n < DEPTH);
      e_uf = bus.pop_en && (preq > n);
      if (bus.pop_en) begin
        e_conc = {(n >= 1) ? mq[0] : PADV, (bus.pop_two && n >= 2) ? mq[1] : PADV};
        e_vld  = {n >= 1, bus.pop_two && n >= 2};
      end else begin
        e_vld = 2'b00;
      end
      pe = (preq < n) ? preq : n;
      repeat (pe) void'(mq.pop_front());
      if (acc) mq.push_back(bus.push_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",      32'(bus.count),      32'(mq.size()));
      chk("push_ready", 32'(bus.push_ready), 32'(mq.size() != DEPTH));
      chk("top_conc",   32'(bus.top_conc),   32'(e_conc));
      chk("top_vld",    32'(bus.top_vld),    32'(e_vld));
      chk("underflow",  32'(bus.underflow),  32'(e_uf));
    end
  end

  task automatic cyc(input bit fl, input bit pv, input logic [7:0] pd, input bit pe, input bit pt);
    bus.flush      = fl;
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_en     = pe;
    bus.pop_two    = pt;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(0, 1, d, 0, 0);
  endtask

  task automatic pop(input bit two);
    cyc(0, 0, 8'h00, 1, two);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    chk_en = 0;
    rst = 1'b1;
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk_en = 1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_conc", 32'(bus.top_conc), 0);
    chk("rst_ready", 32'(bus.push_ready), 1);
    rst = 1'b0;

    push(8'h11); push(8'h22); push(8'h33);
    pop(1);
    chk("pair_conc", 32'(bus.top_conc), 32'h1122);
    chk("pair_vld", 32'(bus.top_vld), 32'h3);
    chk("pair_count", 32'(bus.count), 1);
    pop(0);
    chk("head33_conc", 32'(bus.top_conc), 32'h330A);

    push(8'h44);
    pop(0);
    chk("single_conc", 32'(bus.top_conc), 32'h440A);
    chk("single_vld", 32'(bus.top_vld), 32'h2);
    chk("single_count", 32'(bus.count), 0);

    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("full_ready", 32'(bus.push_ready), 0);
    cyc(0, 1, 8'h66, 1, 0);
    chk("full_count", 32'(bus.count), 4);
    chk("full_ready_after", 32'(bus.push_ready), 1);
    pop(1);
    pop(1);
    chk("drain_conc", 32'(bus.top_conc), 32'h0405);
    chk("drain_count", 32'(bus.count), 0);

    push(8'hAA);
    pop(1);
    chk("uf_conc", 32'(bus.top_conc), 32'hAA0A);
    chk("uf_vld", 32'(bus.top_vld), 32'h2);
    chk("uf_pulse", 32'(bus.underflow), 1);
    cyc(0, 0, 8'h00, 0, 0);
    chk("uf_drop", 32'(bus.underflow), 0);

    cyc(0, 1, 8'h55, 1, 1);
    chk("empty_conc", 32'(bus.top_conc), 32'h0A0A);
    chk("empty_vld", 32'(bus.top_vld), 0);
    chk("empty_count", 32'(bus.count), 1);
    pop(0);

    push(8'h01); push(8'h02); push(8'h03);
    cyc(0, 1, 8'h77, 1, 1);
    chk("pp_count", 32'(bus.count), 2);
    pop(1);
    chk("pp_conc", 32'(bus.top_conc), 32'h0377);

    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    cyc(1, 1, 8'h99, 0, 0);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_conc", 32'(bus.top_conc), 32'h0377);
    push(8'hE1); push(8'hE2);
    rst = 1'b1;
    cyc(0, 1, 8'hE3, 1, 1);
    rst = 1'b0;
    chk("rst_mid_count", 32'(bus.count), 0);
    chk("rst_mid_conc", 32'(bus.top_conc), 0);

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 60, 8'($urandom),
          $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1);
    end
    rst = 1'b0;
    cyc(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
